byte_serial_adder32: RTL and testbench
======================================

# byte_serial_adder32

Multi-cycle 32-bit adder that sits in front of the 8-bit adder datapath. It latches two operands through a valid/ready handshake and drives one byte slice per cycle, carrying between bytes in a register. It assembles the 32-bit sum plus carry, signed-overflow and zero flags, and returns the result through a second valid/ready handshake. It trades throughput for area in non-critical paths, such as cache LRU/age counters and address-offset helpers.

## Interface
- `NBYTES`, 4, number of byte slices; result width = 8*NBYTES. Legal values: 1–8.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset. Asynchronous and active-high.
- `in_valid_i`  in  1  operands present.
- `in_ready_o`  out  1  block can accept operands.
- `a_i`  in  8*NBYTES  operand A.
- `b_i`  in  8*NBYTES  operand B.
- `sub_i`  in  1  1 = A−B. Port exists only with `BSA_SUB_EN`.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer takes the result.
- `sum_o`  out  8*NBYTES  result.
- `carry_o`  out  1  carry out of the MSB. For subtract: 1 = no borrow.
- `overflow_o`  out  1  two's-complement overflow.
- `zero_o`  out  1  `sum_o` is 0.

## Operation
- FSM states: `IDLE`, `CALC`, `DONE`. Reset state is `IDLE`.
- **IDLE**
  - `in_ready_o` = 1.
  - On `in_valid_i && in_ready_o`: latch `a_i` and `b_i` (with `sub_i`: latch ~`b_i`), set the carry register to 0 (with `sub_i`: 1), clear the byte index, go to `CALC`.
- **CALC**
  - Each cycle, byte index k feeds A[k], B'[k] and the carry register to the slice.
  - Slice sum is written to `sum_o` byte k; slice carry-out is written to the carry register.
  - Index increments. After k = NBYTES−1, go to `DONE`.
  - Operand inputs are ignored while in `CALC`; the latched copies are used.
- **DONE**
  - `out_valid_o` = 1.
  - Outputs are held stable until `out_ready_i` = 1, then go to `IDLE`.
- **Back-to-back**: in `DONE`, `in_ready_o` = `out_ready_i`.
  - A simultaneous output and input handshake goes straight to `CALC` with the new operands.
  - `out_valid_o` drops for that cycle's successor.
- **Flags**, registered with the last byte:
  - `carry_o` = final carry register value.
  - `overflow_o` = carry into MSB XOR `carry_o`. Carry into MSB = A[msb] ^ B'[msb] ^ sum[msb].
  - `zero_o` = (`sum_o` == 0).
- **Arithmetic**: modulo 2^(8*NBYTES). No saturation.
- **Reset mid-operation**: any state returns to `IDLE` immediately. The in-flight result is discarded and no `out_valid_o` pulse is produced.
- **Reset values**:
  - `in_ready_o` = 1
  - `out_valid_o` = 0
  - `sum_o` = 0
  - `carry_o` = 0
  - `overflow_o` = 0
  - `zero_o` = 0
  - Internal registers all 0.

## Timing
- **Acceptance edge T0**: byte 0 is computed at edge T1 and byte NBYTES−1 at edge T(NBYTES).
- **Result**: `out_valid_o` is high from cycle T(NBYTES) onward. Default latency is 4 cycles.
- **Throughput**: one result per NBYTES+1 cycles with `out_ready_i` held high (back-to-back path).
- **Timing paths**: all outputs are registered, or decoded directly from FSM state. The only input→output combinational path is `out_ready_i` → `in_ready_o`.
- **Critical path**: one 8-bit ripple plus the carry register.

## Configuration
- **`BSA_SUB_EN` defined**:
  - `sub_i` port is present.
  - Subtract latches the inverted B with carry-in 1.
  - `carry_o` = NOT borrow.
- **`BSA_SUB_EN` not defined**:
  - `sub_i` port is absent.
  - Add only, with carry-in 0.
  - No B-inversion logic is synthesized.

## Structure
- **Package `bsa_pkg`**:
  - `bsa_state_t` enum (`IDLE`, `CALC`, `DONE`).
  - `BYTE_W` = 8.
  - Index-width function `$clog2(NBYTES)`.
- **Sub-module `byte_add_slice`**:
  - 8-bit ripple adder with carry-in and carry-out.
  - Instantiated once and time-multiplexed across bytes.
- **Top level**: FSM, operand/carry/index registers, and flag logic.

## Test plan
- **Byte carry propagation**: 0x000000FF + 0x00000001 → `sum_o` 0x00000100, `carry_o` 0, `overflow_o` 0, `zero_o` 0, `out_valid_o` exactly 4 cycles after acceptance.
- **Full wrap**: 0xFFFFFFFF + 0x00000001 → `sum_o` 0x00000000, `carry_o` 1, `zero_o` 1, `overflow_o` 0.
- **Signed overflow**: 0x7FFFFFFF + 0x00000001 → `sum_o` 0x80000000, `overflow_o` 1, `carry_o` 0.
- **Subtract (`BSA_SUB_EN`)**: 5 − 7 → `sum_o` 0xFFFFFFFE, `carry_o` 0. 7 − 5 → `sum_o` 0x00000002, `carry_o` 1.
- **Backpressure and back-to-back**:
  - Hold `out_ready_i` low 5 cycles: outputs stay stable and `in_ready_o` stays 0.
  - Then raise `out_ready_i` with a new operand valid: new operands are accepted in the same cycle, and the next result follows 4 cycles later.
- **Reset mid-CALC**: assert `rst_i` at byte index 2 → `out_valid_o` 0, `sum_o` 0, `in_ready_o` 1. No stale result appears after reset release.

Source files
------------

// File: rtl/byte_serial_adder32_pkg.sv
// rtl/byte_serial_adder32_pkg.sv - shared types and constants for the byte-serial adder
package bsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

    localparam int BYTE_W = 8;

    // A single-byte build still needs a 1-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/byte_serial_adder32_if.sv
// rtl/byte_serial_adder32_if.sv - operand/result handshake bundle; sub_i present only with BSA_SUB_EN
interface byte_serial_adder32_if #(
    parameter int NBYTES = 4
) ();

    localparam int W = bsa_pkg::BYTE_W * NBYTES;

    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
`ifdef BSA_SUB_EN
    logic         sub_i;
`endif
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         overflow_o;
    logic         zero_o;

    modport slave (
`ifdef BSA_SUB_EN
        input  sub_i,
`endif
        input  in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, carry_o, overflow_o, zero_o
    );

    modport master (
`ifdef BSA_SUB_EN
        output sub_i,
`endif
        output in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, carry_o, overflow_o, zero_o
    );

endinterface

// File: rtl/byte_serial_adder32_slice.sv
// rtl/byte_serial_adder32_slice.sv - 8-bit ripple adder slice shared across all bytes
module byte_add_slice
    import bsa_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/byte_serial_adder32.sv
// rtl/byte_serial_adder32.sv - byte-serial 8*NBYTES adder top; BSA_SUB_EN adds subtract
module byte_serial_adder32
    import bsa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    byte_serial_adder32_if.slave bus
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_width(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    bsa_state_t state, state_next;

    logic [W-1:0]      a_q, b_q, sum_q, sum_next;
    logic              carry_q, c_q, v_q, z_q;
    logic [IW-1:0]     idx_q;
    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              cout;
    logic              in_ready, out_valid, accept;

    assign a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
    assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];

    byte_add_slice u_slice (
        .a   (a_byte),
        .b   (b_byte),
        .cin (carry_q),
        .sum (s_byte),
        .cout(cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid_i) state_next = CALC;
            CALC:    if (idx_q == LAST) state_next = DONE;
            DONE:    if (bus.out_ready_i) state_next = bus.in_valid_i ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The consumer's ready is forwarded so a result and new operands can swap in one cycle.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready_i);
        out_valid = (state == DONE);
    end

    assign accept = bus.in_valid_i && in_ready;

    always_comb begin
        sum_next = sum_q;
        sum_next[idx_q*BYTE_W +: BYTE_W] = s_byte;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a_i;
            idx_q <= '0;
`ifdef BSA_SUB_EN
            b_q     <= bus.sub_i ? ~bus.b_i : bus.b_i;
            carry_q <= bus.sub_i;
`else
            b_q     <= bus.b_i;
            carry_q <= 1'b0;
`endif
        end else if (state == CALC) begin
            sum_q   <= sum_next;
            carry_q <= cout;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST) begin
                c_q <= cout;
                // Carry into the MSB is recovered from the top bit's operands and sum.
                v_q <= a_byte[BYTE_W-1] ^ b_byte[BYTE_W-1] ^ s_byte[BYTE_W-1] ^ cout;
                z_q <= (sum_next == '0);
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.sum_o       = sum_q;
    assign bus.carry_o     = c_q;
    assign bus.overflow_o  = v_q;
    assign bus.zero_o      = z_q;

endmodule

// File: tb/tb_byte_serial_adder32.sv
// tb/tb_byte_serial_adder32.sv - directed bench with an arithmetic reference model
module tb_byte_serial_adder32;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  = 1'b0;
    logic [W-1:0] a_v       = '0;
    logic [W-1:0] b_v       = '0;
    logic         sub_v     = 1'b0;
    logic         out_ready = 1'b1;

    byte_serial_adder32_if #(.NBYTES(NB)) bus ();

    assign bus.in_valid_i  = in_valid;
    assign bus.a_i         = a_v;
    assign bus.b_i         = b_v;
    assign bus.out_ready_i = out_ready;
`ifdef BSA_SUB_EN
    assign bus.sub_i       = sub_v;
`endif

    byte_serial_adder32 #(.NBYTES(NB)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        int           t;
    } exp_t;

    exp_t q[$];
    bit   seen = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
        e.z  = (e.s == '0);
        e.t  = 0;
        return e;
    endfunction

    // Reference compare: every cycle, against the queue of accepted operations.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            seen = 0;
        end else begin
            if (bus.out_valid_o) begin
                if (q.size() == 0) begin
                    chk("stale_out_valid", 1, 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, q[0].t + NB);
                        seen = 1;
                    end
                    chk("model_sum", bus.sum_o, q[0].s);
                    chk("model_carry", bus.carry_o, q[0].c);
                    chk("model_overflow", bus.overflow_o, q[0].v);
                    chk("model_zero", bus.zero_o, q[0].z);
                end
                chk("in_ready_done", bus.in_ready_o, bus.out_ready_i);
                if (bus.out_ready_i && q.size() > 0) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end else begin
                chk("in_ready_busy", bus.in_ready_o, q.size() == 0);
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_t e;
                e   = model(a_v, b_v, sub_v);
                e.t = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic wait_accept(input string name);
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) ok = 1;
        end
        chk({name, "_accept_timeout"}, ok, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] es, input logic ec,
                         input logic ev, input logic ez);
        bit ok = 0;
        int k  = 0;
        a_v = a; b_v = b; sub_v = sub; in_valid = 1'b1; out_ready = 1'b1;
        wait_accept(name);
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) ok = 1;
            else k++;
        end
        chk({name, "_valid_timeout"}, ok, 1);
        chk({name, "_lat"}, k, NB);
        chk({name, "_sum"}, bus.sum_o, es);
        chk({name, "_carry"}, bus.carry_o, ec);
        chk({name, "_ovf"}, bus.overflow_o, ev);
        chk({name, "_zero"}, bus.zero_o, ez);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_in_ready", bus.in_ready_o, 1);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_sum", bus.sum_o, 0);
        chk("rst_carry", bus.carry_o, 0);
        chk("rst_ovf", bus.overflow_o, 0);
        chk("rst_zero", bus.zero_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 0, 0, 0);
        do_op("full_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1);
        do_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0);
        do_op("mixed",      32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 0, 0, 0);
`ifdef BSA_SUB_EN
        do_op("sub_5_7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        do_op("sub_7_5", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1, 0, 0);
`endif

        // Backpressure, then a same-cycle result/operand swap.
        out_ready = 1'b0;
        a_v = 32'h1234_5678; b_v = 32'h1111_1111; sub_v = 1'b0; in_valid = 1'b1;
        wait_accept("bp");
        a_v = 32'h8000_0000; b_v = 32'h8000_0000; in_valid = 1'b1;
        begin
            bit ok = 0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge clk);
                if (bus.out_valid_o) ok = 1;
            end
            chk("bp_valid_timeout", ok, 1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_sum", bus.sum_o, 32'h2345_6789);
            chk("bp_hold_in_ready", bus.in_ready_o, 0);
            chk("bp_hold_valid", bus.out_valid_o, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("b2b_in_ready", bus.in_ready_o, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        begin
            bit ok = 0;
            int k  = 0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge clk);
                if (bus.out_valid_o) ok = 1;
                else k++;
            end
            chk("b2b_valid_timeout", ok, 1);
            chk("b2b_lat", k, NB);
            chk("b2b_sum", bus.sum_o, 32'h0000_0000);
            chk("b2b_carry", bus.carry_o, 1);
            chk("b2b_ovf", bus.overflow_o, 1);
            chk("b2b_zero", bus.zero_o, 1);
        end
        @(posedge clk);
        #1;

        // Reset while the third byte is being computed.
        a_v = 32'hFFFF_FFFF; b_v = 32'hFFFF_FFFF; in_valid = 1'b1;
        wait_accept("rstmid");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_out_valid", bus.out_valid_o, 0);
        chk("rstmid_sum", bus.sum_o, 0);
        chk("rstmid_in_ready", bus.in_ready_o, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rstmid_no_stale", bus.out_valid_o, 0);

        do_op("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
